// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing a dual-port DRAM among NUM_CORES requesters.
// Grants up to two requests per cycle and steers read data back through a per-port tag pipe.
module dram_port_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ID_W      = $clog2(NUM_CORES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CORES-1:0]          core_req,
    input  logic [NUM_CORES-1:0]          core_we,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    output logic [NUM_CORES-1:0]          core_ack,
    output logic [NUM_CORES-1:0]          core_rvalid,
    output logic [NUM_CORES*DATA_W-1:0]   core_rdata,
    output logic                          dram_we_1,
    output logic [ADDR_W-1:0]             dram_addr_1,
    output logic [DATA_W-1:0]             dram_wdata_1,
    input  logic [DATA_W-1:0]             dram_rdata_1,
    output logic                          dram_we_2,
    output logic [ADDR_W-1:0]             dram_addr_2,
    output logic [DATA_W-1:0]             dram_wdata_2,
    input  logic [DATA_W-1:0]             dram_rdata_2
);

    localparam logic [ID_W:0] NumCoresW = NUM_CORES[ID_W:0];
    localparam logic [ID_W:0] OneW      = {{ID_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0]         addr_a  [NUM_CORES];
    logic [DATA_W-1:0]         wdata_a [NUM_CORES];
    logic [NUM_CORES-1:0]      eligible;
    logic [ID_W-1:0]           rr_ptr_q;
    logic [ID_W-1:0]           idx, p1, p2, last, rr_next;
    logic                      found1, found2, grant2;
    logic [NUM_CORES-1:0]      ack_d;
    logic [NUM_CORES-1:0]      rvalid_d;
    logic [NUM_CORES*DATA_W-1:0] rdata_d;

    // Read tag pipe, one {valid, id} per port per stage
    logic            s1_v1_q, s1_v2_q, s2_v1_q, s2_v2_q;
    logic [ID_W-1:0] s1_id1_q, s1_id2_q, s2_id1_q, s2_id2_q;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_split
        assign addr_a[g]  = core_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = core_wdata[g*DATA_W +: DATA_W];
    end

    // Cores acked this cycle already had their op taken; their fields may be changing.
    assign eligible = core_req & ~core_ack;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input logic [ID_W:0]   off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= NumCoresW) sum = sum - NumCoresW;
        return sum[ID_W-1:0];
    endfunction

    always_comb begin
        found1 = 1'b0;
        found2 = 1'b0;
        p1     = '0;
        p2     = '0;
        idx    = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            idx = wrap_add(rr_ptr_q, k[ID_W:0]);
            if (eligible[idx]) begin
                if (!found1) begin
                    found1 = 1'b1;
                    p1     = idx;
                end else if (!found2) begin
                    found2 = 1'b1;
                    p2     = idx;
                end
            end
        end
        // Same-address pair with a write would race inside the DRAM; defer the second.
        grant2  = found2 && !((addr_a[p1] == addr_a[p2]) && (core_we[p1] || core_we[p2]));
        last    = grant2 ? p2 : p1;
        rr_next = wrap_add(last, OneW);
        ack_d   = '0;
        if (found1) ack_d[p1] = 1'b1;
        if (grant2) ack_d[p2] = 1'b1;
    end

    always_comb begin
        rvalid_d = '0;
        rdata_d  = core_rdata;
        if (s2_v1_q) begin
            rvalid_d[s2_id1_q]                   = 1'b1;
            rdata_d[s2_id1_q*DATA_W +: DATA_W] = dram_rdata_1;
        end
        if (s2_v2_q) begin
            rvalid_d[s2_id2_q]                   = 1'b1;
            rdata_d[s2_id2_q*DATA_W +: DATA_W] = dram_rdata_2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            core_ack     <= '0;
            core_rvalid  <= '0;
            core_rdata   <= '0;
            dram_we_1    <= 1'b0;
            dram_addr_1  <= '0;
            dram_wdata_1 <= '0;
            dram_we_2    <= 1'b0;
            dram_addr_2  <= '0;
            dram_wdata_2 <= '0;
            s1_v1_q      <= 1'b0;
            s1_v2_q      <= 1'b0;
            s2_v1_q      <= 1'b0;
            s2_v2_q      <= 1'b0;
            s1_id1_q     <= '0;
            s1_id2_q     <= '0;
            s2_id1_q     <= '0;
            s2_id2_q     <= '0;
        end else begin
            core_ack <= ack_d;
            if (found1) rr_ptr_q <= rr_next;
            dram_we_1 <= found1 && core_we[p1];
            if (found1) begin
                dram_addr_1  <= addr_a[p1];
                dram_wdata_1 <= wdata_a[p1];
            end
            dram_we_2 <= grant2 && core_we[p2];
            if (grant2) begin
                dram_addr_2  <= addr_a[p2];
                dram_wdata_2 <= wdata_a[p2];
            end
            s1_v1_q     <= found1 && !core_we[p1];
            s1_id1_q    <= p1;
            s1_v2_q     <= grant2 && !core_we[p2];
            s1_id2_q    <= p2;
            s2_v1_q     <= s1_v1_q;
            s2_id1_q    <= s1_id1_q;
            s2_v2_q     <= s1_v2_q;
            s2_id2_q    <= s1_id2_q;
            core_rvalid <= rvalid_d;
            core_rdata  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model and a behavioural DRAM.
module tb_dram_port_arbiter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  core_req, core_we, core_ack, core_rvalid;
    logic [63:0]   core_addr, core_wdata, core_rdata;
    logic          dram_we_1, dram_we_2;
    logic [15:0]   dram_addr_1, dram_wdata_1, dram_rdata_1;
    logic [15:0]   dram_addr_2, dram_wdata_2, dram_rdata_2;
    logic [15:0]   addr_t [N];
    logic [15:0]   wdata_t [N];
    logic [15:0]   dram_mem [logic [15:0]];
    logic [15:0]   ref_mem [logic [15:0]];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    assign core_addr  = {addr_t[3], addr_t[2], addr_t[1], addr_t[0]};
    assign core_wdata = {wdata_t[3], wdata_t[2], wdata_t[1], wdata_t[0]};

    dram_port_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_ack(core_ack), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .dram_we_1(dram_we_1), .dram_addr_1(dram_addr_1), .dram_wdata_1(dram_wdata_1),
        .dram_rdata_1(dram_rdata_1),
        .dram_we_2(dram_we_2), .dram_addr_2(dram_addr_2), .dram_wdata_2(dram_wdata_2),
        .dram_rdata_2(dram_rdata_2)
    );

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] dram_rd(input logic [15:0] a);
        return dram_mem.exists(a) ? dram_mem[a] : init_val(a);
    endfunction

    function automatic logic [15:0] rslice(input int i);
        return core_rdata[i*16 +: 16];
    endfunction

    // Behavioural DRAM: executes the registered command one edge later.
    always @(posedge clk) begin
        dram_rdata_1 <= dram_rd(dram_addr_1);
        dram_rdata_2 <= dram_rd(dram_addr_2);
        if (dram_we_1) dram_mem[dram_addr_1] = dram_wdata_1;
        if (dram_we_2) dram_mem[dram_addr_2] = dram_wdata_2;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        core_req = '0;
        core_we  = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        core_req = 4'hF;
        core_we  = 4'h0;
        for (int i = 0; i < N; i++) addr_t[i] = 16'h0100 + 16'(i);
        cyc();
        cyc();
        n_vec++; if (core_ack !== 4'b0) begin n_err++; $display("FAIL reset_ack: got %b expected 0000", core_ack); end
        n_vec++; if (core_rvalid !== 4'b0) begin n_err++; $display("FAIL reset_rvalid: got %b expected 0000", core_rvalid); end
        n_vec++; if (dram_we_1 !== 1'b0 || dram_we_2 !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b%b expected 00", dram_we_1, dram_we_2); end
        n_vec++; if (dram_addr_1 !== 16'h0 || core_rdata !== 64'h0) begin n_err++; $display("FAIL reset_regs: got addr %h rdata %h expected 0", dram_addr_1, core_rdata); end
        rst_n = 1'b1;
        cyc();
        n_vec++; if (core_ack !== 4'b0011) begin n_err++; $display("FAIL reset_first_grant: got %b expected 0011", core_ack); end
        n_vec++; if (dram_addr_1 !== 16'h0100 || dram_addr_2 !== 16'h0101) begin n_err++; $display("FAIL reset_first_ports: got %h/%h expected 0100/0101", dram_addr_1, dram_addr_2); end
        core_req = '0;
    endtask

    task automatic test_single_read();
        do_reset();
        dram_mem[16'h0010] = 16'h0055;
        core_req  = 4'b0100;
        core_we   = '0;
        addr_t[2] = 16'h0010;
        cyc();
        n_vec++; if (dram_addr_1 !== 16'h0010 || dram_we_1 !== 1'b0) begin n_err++; $display("FAIL single_cmd: got addr %h we %b expected 0010/0", dram_addr_1, dram_we_1); end
        n_vec++; if (core_ack !== 4'b0100) begin n_err++; $display("FAIL single_ack: got %b expected 0100", core_ack); end
        core_req = '0;
        cyc();
        n_vec++; if (core_rvalid !== 4'b0) begin n_err++; $display("FAIL single_early_rvalid: got %b expected 0000", core_rvalid); end
        cyc();
        n_vec++; if (core_rvalid !== 4'b0100) begin n_err++; $display("FAIL single_rvalid: got %b expected 0100", core_rvalid); end
        n_vec++; if (rslice(2) !== 16'h0055) begin n_err++; $display("FAIL single_rdata: got %h expected 0055", rslice(2)); end
        cyc();
        n_vec++; if (core_rvalid !== 4'b0 || rslice(2) !== 16'h0055) begin n_err++; $display("FAIL single_hold: got rvalid %b data %h expected 0000/0055", core_rvalid, rslice(2)); end
    endtask

    task automatic test_all_read();
        logic [3:0] exp;
        do_reset();
        for (int i = 0; i < N; i++) addr_t[i] = 16'h0200 + 16'(i);
        core_we  = '0;
        core_req = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            exp = (k % 2 == 1) ? 4'b0011 : 4'b1100;
            n_vec++; if (core_ack !== exp) begin n_err++; $display("FAIL all_ack k=%0d: got %b expected %b", k, core_ack, exp); end
            if (k >= 3) begin
                n_vec++; if (core_rvalid !== exp) begin n_err++; $display("FAIL all_rvalid k=%0d: got %b expected %b", k, core_rvalid, exp); end
                for (int i = 0; i < N; i++) begin
                    if (exp[i]) begin
                        n_vec++;
                        if (rslice(i) !== init_val(16'h0200 + 16'(i))) begin
                            n_err++; $display("FAIL all_rdata k=%0d core %0d: got %h expected %h", k, i, rslice(i), init_val(16'h0200 + 16'(i)));
                        end
                    end
                end
            end else begin
                n_vec++; if (core_rvalid !== 4'b0) begin n_err++; $display("FAIL all_early_rvalid k=%0d: got %b expected 0000", k, core_rvalid); end
            end
        end
        core_req = '0;
    endtask

    task automatic test_hazard();
        do_reset();
        core_req   = 4'b0011;
        core_we    = 4'b0001;
        addr_t[0]  = 16'h0020;
        wdata_t[0] = 16'h00AA;
        addr_t[1]  = 16'h0020;
        cyc();
        n_vec++; if (core_ack !== 4'b0001) begin n_err++; $display("FAIL hazard_ack1: got %b expected 0001", core_ack); end
        n_vec++; if (dram_we_1 !== 1'b1 || dram_addr_1 !== 16'h0020 || dram_we_2 !== 1'b0) begin n_err++; $display("FAIL hazard_ports1: got we1 %b addr1 %h we2 %b expected 1/0020/0", dram_we_1, dram_addr_1, dram_we_2); end
        core_req[0] = 1'b0;
        cyc();
        n_vec++; if (core_ack !== 4'b0010) begin n_err++; $display("FAIL hazard_ack2: got %b expected 0010", core_ack); end
        n_vec++; if (dram_we_1 !== 1'b0 || dram_addr_1 !== 16'h0020) begin n_err++; $display("FAIL hazard_ports2: got we1 %b addr1 %h expected 0/0020", dram_we_1, dram_addr_1); end
        core_req[1] = 1'b0;
        cyc();
        cyc();
        n_vec++; if (core_rvalid !== 4'b0010 || rslice(1) !== 16'h00AA) begin n_err++; $display("FAIL hazard_read: got rvalid %b data %h expected 0010/00AA", core_rvalid, rslice(1)); end
    endtask

    task automatic test_dual_write();
        do_reset();
        core_req   = 4'b1100;
        core_we    = 4'b1100;
        addr_t[2]  = 16'h0030;
        wdata_t[2] = 16'h1234;
        addr_t[3]  = 16'h0031;
        wdata_t[3] = 16'h5678;
        cyc();
        n_vec++; if (core_ack !== 4'b1100) begin n_err++; $display("FAIL dualw_ack: got %b expected 1100", core_ack); end
        n_vec++; if (dram_we_1 !== 1'b1 || dram_we_2 !== 1'b1) begin n_err++; $display("FAIL dualw_we: got %b%b expected 11", dram_we_1, dram_we_2); end
        n_vec++; if (dram_addr_1 !== 16'h0030 || dram_addr_2 !== 16'h0031) begin n_err++; $display("FAIL dualw_addr: got %h/%h expected 0030/0031", dram_addr_1, dram_addr_2); end
        core_req = '0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_vec++; if (core_rvalid !== 4'b0) begin n_err++; $display("FAIL dualw_no_rvalid k=%0d: got %b expected 0000", k, core_rvalid); end
        end
        core_we   = '0;
        addr_t[0] = 16'h0031;
        addr_t[1] = 16'h0030;
        core_req  = 4'b0011;
        cyc();
        n_vec++; if (core_ack !== 4'b0011) begin n_err++; $display("FAIL dualw_rd_ack: got %b expected 0011", core_ack); end
        core_req = '0;
        cyc();
        cyc();
        n_vec++; if (core_rvalid !== 4'b0011) begin n_err++; $display("FAIL dualw_rd_rvalid: got %b expected 0011", core_rvalid); end
        n_vec++; if (rslice(0) !== 16'h5678 || rslice(1) !== 16'h1234) begin n_err++; $display("FAIL dualw_rd_data: got %h/%h expected 5678/1234", rslice(0), rslice(1)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        core_req  = 4'b0001;
        core_we   = '0;
        addr_t[0] = 16'h0040;
        cyc();
        n_vec++; if (core_ack !== 4'b0001) begin n_err++; $display("FAIL mid_ack: got %b expected 0001", core_ack); end
        core_req = '0;
        cyc();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 1) rst_n = 1'b1;
            n_vec++; if (core_rvalid !== 4'b0) begin n_err++; $display("FAIL mid_no_rvalid k=%0d: got %b expected 0000", k, core_rvalid); end
        end
        addr_t[0] = 16'h0041;
        addr_t[3] = 16'h0043;
        core_req  = 4'b1001;
        cyc();
        n_vec++; if (dram_addr_1 !== 16'h0041 || dram_addr_2 !== 16'h0043) begin n_err++; $display("FAIL mid_rr_ptr: got %h/%h expected 0041/0043", dram_addr_1, dram_addr_2); end
        n_vec++; if (core_ack !== 4'b1001) begin n_err++; $display("FAIL mid_post_ack: got %b expected 1001", core_ack); end
        core_req = '0;
    endtask

    // Reference access: writes land immediately, reads see all earlier-granted writes.
    function automatic logic [15:0] ref_access(input int c);
        if (core_we[c]) begin
            ref_mem[addr_t[c]] = wdata_t[c];
            return 16'h0;
        end
        return ref_mem.exists(addr_t[c]) ? ref_mem[addr_t[c]] : init_val(addr_t[c]);
    endfunction

    task automatic test_random(input int ncyc);
        logic [3:0]  ack_m, nack;
        logic [3:0]  ev [8];
        logic [15:0] ed [8][4];
        logic [15:0] v;
        int          rr_m, last, p1, p2, s, w, c;
        int          q[$];
        do_reset();
        ack_m = '0;
        rr_m  = 0;
        for (int j = 0; j < 8; j++) begin
            ev[j] = '0;
            for (int i = 0; i < N; i++) ed[j][i] = '0;
        end
        for (int t = 0; t < ncyc; t++) begin
            s = t % 8;
            w = (t + 3) % 8;
            n_vec++; if (core_ack !== ack_m) begin n_err++; $display("FAIL rand_ack t=%0d: got %b expected %b", t, core_ack, ack_m); end
            n_vec++; if (core_rvalid !== ev[s]) begin n_err++; $display("FAIL rand_rvalid t=%0d: got %b expected %b", t, core_rvalid, ev[s]); end
            for (int i = 0; i < N; i++) begin
                if (ev[s][i]) begin
                    n_vec++;
                    if (rslice(i) !== ed[s][i]) begin n_err++; $display("FAIL rand_rdata t=%0d core %0d: got %h expected %h", t, i, rslice(i), ed[s][i]); end
                end
            end
            ev[s] = '0;
            for (int i = 0; i < N; i++) begin
                if (ack_m[i] || !core_req[i]) begin
                    core_req[i] = (t < ncyc - 8) && ($urandom_range(0, 3) != 0);
                    core_we[i]  = ($urandom_range(0, 2) == 0);
                    addr_t[i]   = 16'($urandom_range(0, 7));
                    wdata_t[i]  = 16'($urandom);
                end
            end
            q.delete();
            for (int k = 0; k < N; k++) begin
                c = (rr_m + k) % N;
                if (core_req[c] && !ack_m[c]) q.push_back(c);
            end
            nack = '0;
            if (q.size() > 0) begin
                p1 = q[0];
                last = p1;
                nack[p1] = 1'b1;
                v = ref_access(p1);
                if (!core_we[p1]) begin ev[w][p1] = 1'b1; ed[w][p1] = v; end
                if (q.size() > 1) begin
                    p2 = q[1];
                    if (!(addr_t[p1] == addr_t[p2] && (core_we[p1] || core_we[p2]))) begin
                        last = p2;
                        nack[p2] = 1'b1;
                        v = ref_access(p2);
                        if (!core_we[p2]) begin ev[w][p2] = 1'b1; ed[w][p2] = v; end
                    end
                end
                rr_m = (last + 1) % N;
            end
            ack_m = nack;
            cyc();
        end
        core_req = '0;
    endtask

    initial begin
        rst_n    = 1'b0;
        core_req = '0;
        core_we  = '0;
        for (int i = 0; i < N; i++) begin
            addr_t[i]  = '0;
            wdata_t[i] = '0;
        end
        test_reset();
        test_single_read();
        test_all_read();
        test_hazard();
        test_dual_write();
        test_reset_mid();
        test_random(800);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
